// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack: jump, advance, call and return,
// with sticky overflow/underflow flags for calls into a full stack and returns from an empty one.
module pc_call_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int STEP  = 1
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               in,
    input  logic                           load,
    input  logic                           inc,
    input  logic                           call,
    input  logic                           ret,
    output logic [WIDTH-1:0]               out,
    output logic [$clog2(DEPTH+1)-1:0]     sp,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] next_pc;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic             push;

    assign next_pc = out + WIDTH'(STEP);
    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);
    assign wr_idx  = sp[IW-1:0];
    // When DEPTH is a power of two a full sp truncates to 0 and the -1 wraps to DEPTH-1.
    assign rd_idx  = sp[IW-1:0] - IW'(1);
    assign push    = !reset && !load && call && !full;

    always_ff @(posedge CLK) begin
        if (reset) begin
            out       <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (load) begin
            out <= in;
        end else if (call) begin
            if (!full) begin
                out <= in;
                sp  <= sp + SPW'(1);
            end else begin
                overflow <= 1'b1;
            end
        end else if (ret) begin
            if (!empty) begin
                out <= stack[rd_idx];
                sp  <= sp - SPW'(1);
            end else begin
                underflow <= 1'b1;
            end
        end else if (inc) begin
            out <= next_pc;
        end
    end

    // NOTE: the stack array has no reset; entries at or above sp are never read, so clearing them buys nothing.
    always_ff @(posedge CLK) begin
        if (push) begin
            stack[wr_idx] <= next_pc;
        end
    end

endmodule
